// File: rtl/mandel_scan_ctrl_if.sv
// Pipeline-side and pixel-side bus of the Mandelbrot scan controller.
// master = controller, slave = iteration pipeline plus framebuffer writer.
interface mandel_scan_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int XW    = 10,
    parameter int YW    = 9
);
    logic [WIDTH-1:0] c_real;
    logic [WIDTH-1:0] c_imag;
    logic             c_valid;
    logic             overflow;
    logic [XW-1:0]    pix_x;
    logic [YW-1:0]    pix_y;
    logic             pix_data;
    logic             pix_valid;
    logic             pix_ready;

    modport master (
        output c_real, c_imag, c_valid, pix_x, pix_y, pix_data, pix_valid,
        input  overflow, pix_ready
    );

    modport slave (
        input  c_real, c_imag, c_valid, pix_x, pix_y, pix_data, pix_valid,
        output overflow, pix_ready
    );
endinterface

// File: rtl/mandel_scan_ctrl.sv
// Frame-scan controller: issues viewport points into the fixed-latency pipeline and
// returns results as raster pixels. Optional MANDEL_SCAN_PERFCNT_EN adds stall_cycles.
module mandel_scan_ctrl #(
    parameter int WIDTH      = 32,
    parameter int LATENCY    = 14,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int XW         = 10,
    parameter int YW         = 9,
    parameter int FIFO_DEPTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] y0,
    input  logic [WIDTH-1:0] step,
    output logic             busy,
    output logic             done,
`ifdef MANDEL_SCAN_PERFCNT_EN
    output logic [31:0]      stall_cycles,
`endif
    mandel_scan_ctrl_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] x0_q, step_q;
    logic [WIDTH-1:0] pt_re, pt_im;
    logic [WIDTH-1:0] c_real_q, c_imag_q;
    logic             c_valid_q;
    logic [XW-1:0]    ix, ox;
    logic [YW-1:0]    iy, oy;
    logic [LATENCY-1:0] sr;
    logic             rs_valid, rs_data;
    logic [CW-1:0]    inflight, count;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             mem [FIFO_DEPTH];
    logic             done_q;

    logic             credit, issue, push, pop, pix_valid;
    logic             last_col, last_row, last_pix;
    logic             start_ok, done_next;

    // A result still in the pipeline or the result register holds a FIFO slot.
    assign credit    = ({1'b0, inflight} + {1'b0, count}) < (CW + 1)'(FIFO_DEPTH);
    assign issue     = (state == S_RUN) && credit;
    assign last_col  = (ix == XW'(H_RES - 1));
    assign last_row  = (iy == YW'(V_RES - 1));
    assign push      = rs_valid;
    assign pix_valid = (count != '0);
    assign pop       = pix_valid && bus.pix_ready;
    assign last_pix  = pop && (ox == XW'(H_RES - 1)) && (oy == YW'(V_RES - 1));

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        next_state = state;
        start_ok   = 1'b0;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_RUN;
                    start_ok   = 1'b1;
                end
            end
            S_RUN: begin
                if (issue && last_col && last_row) next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (last_pix) begin
                    next_state = S_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            done_q    <= 1'b0;
            x0_q      <= '0;
            step_q    <= '0;
            pt_re     <= '0;
            pt_im     <= '0;
            c_real_q  <= '0;
            c_imag_q  <= '0;
            c_valid_q <= 1'b0;
            ix        <= '0;
            iy        <= '0;
            sr        <= '0;
            rs_valid  <= 1'b0;
            rs_data   <= 1'b0;
            inflight  <= '0;
            count     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ox        <= '0;
            oy        <= '0;
        end else begin
            state     <= next_state;
            done_q    <= done_next;
            c_valid_q <= issue;

            if (start_ok) begin
                x0_q     <= x0;
                step_q   <= step;
                pt_re    <= x0;
                pt_im    <= y0;
                c_real_q <= x0;
                c_imag_q <= y0;
                ix       <= '0;
                iy       <= '0;
            end else if (issue) begin
                c_real_q <= pt_re;
                c_imag_q <= pt_im;
                if (last_col) begin
                    ix    <= '0;
                    iy    <= last_row ? '0 : iy + YW'(1);
                    pt_re <= x0_q;
                    pt_im <= pt_im - step_q;
                end else begin
                    ix    <= ix + XW'(1);
                    pt_re <= pt_re + step_q;
                end
            end

            // Tail of the shift register marks the cycle whose overflow belongs to us.
            sr       <= {sr[LATENCY-2:0], issue};
            rs_valid <= sr[LATENCY-1];
            rs_data  <= ~bus.overflow;

            case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);

            if (pop) begin
                if (ox == XW'(H_RES - 1)) begin
                    ox <= '0;
                    oy <= (oy == YW'(V_RES - 1)) ? '0 : oy + YW'(1);
                end else begin
                    ox <= ox + XW'(1);
                end
            end
        end
    end

    // NOTE: storage is not reset; clearing the pointers and count empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rs_data;
    end

`ifdef MANDEL_SCAN_PERFCNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset || start_ok)              stall_q <= '0;
        else if (state == S_RUN && !credit) stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`endif

    assign busy          = (state != S_IDLE);
    assign done          = done_q;
    assign bus.c_real    = c_real_q;
    assign bus.c_imag    = c_imag_q;
    assign bus.c_valid   = c_valid_q;
    assign bus.pix_x     = ox;
    assign bus.pix_y     = oy;
    assign bus.pix_valid = pix_valid;
    assign bus.pix_data  = pix_valid & mem[rd_ptr];
endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Scoreboard bench for mandel_scan_ctrl on a 4x2 viewport with a 4-entry result FIFO
// and a behavioural latency-14 pipeline model.
module tb_mandel_scan_ctrl;
    localparam int WIDTH      = 32;
    localparam int LATENCY    = 14;
    localparam int H_RES      = 4;
    localparam int V_RES      = 2;
    localparam int XW         = 10;
    localparam int YW         = 9;
    localparam int FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] x0 = '0, y0 = '0, step = '0;
    logic             busy, done;
    logic             ovf;
    logic             pix_ready = 1'b1;
`ifdef MANDEL_SCAN_PERFCNT_EN
    logic [31:0]      stall_cycles;
`endif

    mandel_scan_ctrl_if #(.WIDTH(WIDTH), .XW(XW), .YW(YW)) bus ();
    assign bus.overflow  = ovf;
    assign bus.pix_ready = pix_ready;

    mandel_scan_ctrl #(
        .WIDTH(WIDTH), .LATENCY(LATENCY), .H_RES(H_RES), .V_RES(V_RES),
        .XW(XW), .YW(YW), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .x0(x0),
        .y0(y0),
        .step(step),
        .busy(busy),
        .done(done),
`ifdef MANDEL_SCAN_PERFCNT_EN
        .stall_cycles(stall_cycles),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [WIDTH-1:0] re; logic [WIDTH-1:0] im;} c_exp_t;
    typedef struct packed {logic [XW-1:0] x; logic [YW-1:0] y; logic d;} p_exp_t;

    c_exp_t c_q[$];
    p_exp_t p_q[$];
    c_exp_t ce;
    p_exp_t pe;

    int checks = 0, failures = 0;
    int done_count = 0, c_issued = 0, pix_seen = 0;
    int model_mode = 0;

    // Hand-computed viewport coordinates and expected pix_data per model mode.
    logic [WIDTH-1:0] tbl_re [H_RES];
    logic [WIDTH-1:0] tbl_im [V_RES];
    bit pd_tbl [2][V_RES][H_RES] = '{'{'{1, 0, 1, 0}, '{1, 0, 1, 0}},
                                     '{'{0, 1, 1, 1}, '{1, 0, 1, 1}}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mode 0: odd columns escape. Mode 1: the diagonal col==row escapes.
    function automatic logic model_ovf(input logic [WIDTH-1:0] re, input logic [WIDTH-1:0] im);
        int col = 0;
        int row = 0;
        for (int i = 0; i < H_RES; i++) if (tbl_re[i] == re) col = i;
        for (int j = 0; j < V_RES; j++) if (tbl_im[j] == im) row = j;
        return (model_mode == 0) ? (col % 2 == 1) : (col == row);
    endfunction

    // Pipeline model; it is not reset, so abandoned points keep flowing out.
    logic pv  [LATENCY-1] = '{default: 1'b0};
    logic pov [LATENCY-1] = '{default: 1'b0};
    logic junk = 1'b0;

    always @(posedge clk) begin
        for (int i = LATENCY - 2; i > 0; i--) begin
            pv[i]  <= pv[i-1];
            pov[i] <= pov[i-1];
        end
        pv[0]  <= bus.c_valid;
        pov[0] <= model_ovf(bus.c_real, bus.c_imag);
        junk   <= 1'($urandom_range(0, 1));
    end

    assign ovf = pv[LATENCY-2] ? pov[LATENCY-2] : junk;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.c_valid) begin
                c_issued++;
                if (c_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL c_extra: unexpected issue c_real=%0h c_imag=%0h", bus.c_real, bus.c_imag);
                end else begin
                    ce = c_q.pop_front();
                    check("c_real", bus.c_real, ce.re);
                    check("c_imag", bus.c_imag, ce.im);
                end
            end
            if (bus.pix_valid && pix_ready) begin
                pix_seen++;
                if (p_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pix_extra: unexpected pixel x=%0d y=%0d", bus.pix_x, bus.pix_y);
                end else begin
                    pe = p_q.pop_front();
                    check("pix_x", bus.pix_x, pe.x);
                    check("pix_y", bus.pix_y, pe.y);
                    check("pix_data", bus.pix_data, pe.d);
                end
            end
            if (done) done_count++;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"},      busy,          0);
        check({tag, "_done"},      done,          0);
        check({tag, "_c_valid"},   bus.c_valid,   0);
        check({tag, "_pix_valid"}, bus.pix_valid, 0);
        check({tag, "_pix_data"},  bus.pix_data,  0);
        check({tag, "_c_real"},    bus.c_real,    0);
        check({tag, "_c_imag"},    bus.c_imag,    0);
        check({tag, "_pix_x"},     bus.pix_x,     0);
        check({tag, "_pix_y"},     bus.pix_y,     0);
    endtask

    task automatic push_expect(input int mode);
        for (int r = 0; r < V_RES; r++)
            for (int c = 0; c < H_RES; c++) begin
                c_q.push_back('{re: tbl_re[c], im: tbl_im[r]});
                p_q.push_back('{x: XW'(c), y: YW'(r), d: pd_tbl[mode][r][c]});
            end
    endtask

    // exp_cycles counts edges from the start-sampling edge to the edge after which done is seen.
    task automatic run_frame(input logic [WIDTH-1:0] x0v, input logic [WIDTH-1:0] y0v,
                             input logic [WIDTH-1:0] stepv, input int mode, input bit bp,
                             input bit spulse, input int exp_cycles);
        int cyc;
        bit got;
        model_mode = mode;
        push_expect(mode);
        done_count = 0;
        c_issued   = 0;
        pix_seen   = 0;
        pix_ready  = !bp;
        x0 = x0v;
        y0 = y0v;
        step = stepv;
        start = 1'b1;
        tick;
        check("busy_after_start", busy, 1);
        check("c_valid_at_start", bus.c_valid, 0);
        check("c_real_on_entry", bus.c_real, x0v);
        start = 1'b0;
        x0 = 32'h0BAD0BAD;
        y0 = 32'h0BAD0BAD;
        step = 32'h0BAD0BAD;
        tick;
        cyc = 1;
        check("c_valid_first", bus.c_valid, 1);
        got = 1'b0;
        while (!got && cyc < 600) begin
            if (bp) pix_ready = (cyc >= 40);
            if (bp && cyc == 39) begin
                check("bp_issue_count", c_issued, 4);
                check("bp_pix_valid", bus.pix_valid, 1);
            end
            if (spulse) begin
                start = (cyc == 10 || cyc == 25);
                x0 = 32'h12345678;
                if (cyc == 30) check("busy_in_drain", busy, 1);
            end
            if (done) got = 1'b1;
            else begin
                tick;
                cyc++;
            end
        end
        start = 1'b0;
        pix_ready = 1'b1;
        check("done_seen", got, 1);
        check("busy_low_with_done", busy, 0);
        if (exp_cycles > 0) check("done_latency", cyc, exp_cycles);
        tick;
        tick;
        check("done_once", done_count, 1);
        check("done_pulse_low", done, 0);
        check("pix_count", pix_seen, 8);
        check("c_q_empty", c_q.size(), 0);
        check("p_q_empty", p_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick;
        check_reset_state("por");
        reset = 1'b0;
        tick;

        // Raster sweep with odd-column escapes.
        tbl_re = '{32'hF8000000, 32'hF8400000, 32'hF8800000, 32'hF8C00000};
        tbl_im = '{32'h00400000, 32'h00000000};
        run_frame(32'hF8000000, 32'h00400000, 32'h00400000, 0, 1'b0, 1'b0, 37);

        // Backpressure: pix_ready low until the credit limit stalls issue.
        run_frame(32'hF8000000, 32'h00400000, 32'h00400000, 1, 1'b1, 1'b0, -1);

        // Start pulses in RUN and DRAIN are ignored.
        run_frame(32'hF8000000, 32'h00400000, 32'h00400000, 0, 1'b0, 1'b1, 37);

        // One-cycle reset mid-RUN, then a clean frame while stale results drain from the model.
        model_mode = 0;
        push_expect(0);
        x0 = 32'hF8000000;
        y0 = 32'h00400000;
        step = 32'h00400000;
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_reset_state("mid_reset");
        c_q.delete();
        p_q.delete();
        run_frame(32'hF8000000, 32'h00400000, 32'h00400000, 1, 1'b0, 1'b0, 37);

        // Two's-complement wrap on c_real and c_imag.
        tbl_re = '{32'h7FC00000, 32'h80000000, 32'h80400000, 32'h80800000};
        tbl_im = '{32'h00000000, 32'hFFC00000};
        run_frame(32'h7FC00000, 32'h00000000, 32'h00400000, 0, 1'b0, 1'b0, 37);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mandel_scan_ctrl.md
# mandel_scan_ctrl

Frame-scan controller that drives the Mandelbrot iteration pipeline and collects its results. It sweeps a rectangular viewport of the complex plane and issues one `c` point per cycle into the fixed-latency, non-stallable pipeline. It tracks in-flight points, buffers the returned `overflow` flags in a result FIFO, and presents them as raster-ordered pixels on a valid/ready write port toward the framebuffer writer.

## Interface
- `WIDTH`, 32: fixed-point width of `c` values (Q10.22, two's complement).
- `LATENCY`, 14: clocks from a `c_valid` sample to the matching `overflow` sample. Must equal the pipeline latency (13 iterations + result register).
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.
- `XW`, 10: width of `pix_x`.
- `YW`, 9: width of `pix_y`.
- `FIFO_DEPTH`, 32: result FIFO entries (power of two, ≥ 2).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a frame; sampled only in IDLE.
- `x0` in WIDTH: real part of the top-left point.
- `y0` in WIDTH: imaginary part of the top-left point.
- `step` in WIDTH: per-pixel increment.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse after the last pixel handshake.
- `c_real` out WIDTH: pipeline input, real part.
- `c_imag` out WIDTH: pipeline input, imaginary part.
- `c_valid` out 1: issued point is meaningful this cycle.
- `overflow` in 1: pipeline result (1 = escaped).
- `pix_x` out XW: pixel column.
- `pix_y` out YW: pixel row.
- `pix_data` out 1: 1 = point inside the set (`~overflow`).
- `pix_valid` out 1: pixel offered.
- `pix_ready` in 1: pixel accepted.

## Operation
- States:
  - IDLE: `start` → RUN. On entry, latch `x0`, `y0`, `step`; set issue counters ix = iy = 0, `c_real` = `x0`, `c_imag` = `y0`.
  - RUN: issue points. After issuing the last point (ix = H_RES-1, iy = V_RES-1) → DRAIN.
  - DRAIN: no issue. When the output counters reach the last pixel and it handshakes → IDLE with `done` = 1.
- Issue rule: issue in a cycle only if `inflight + fifo_count < FIFO_DEPTH`.
  - Issue sets `c_valid` = 1 and presents the current `c_real`/`c_imag`.
  - Otherwise `c_valid` = 0 and `c_real`/`c_imag` hold.
- Point stepping: after each issue, `c_real += step`.
  - At line end, `c_real` reloads to the latched `x0` and `c_imag -= step` (rows go downward).
  - Addition wraps modulo 2^WIDTH; no saturation.
- In-flight tracking:
  - `c_valid` also enters a LATENCY-bit shift register.
  - A 1 at the tail means `overflow` is valid this cycle; push `~overflow` into the FIFO.
  - `inflight` is a counter: +1 on issue, −1 on tail pop; both in the same cycle leaves it unchanged.
  - `overflow` is ignored when the tail bit is 0.
- Output side:
  - `pix_valid` = FIFO not empty; `pix_data` = FIFO head.
  - Separate counters ox/oy drive `pix_x`/`pix_y` and advance only on `pix_valid & pix_ready`, wrapping at H_RES/V_RES.
- Simultaneous FIFO push and pop: count unchanged. The credit rule guarantees the FIFO never overflows.
- `start` in RUN or DRAIN is ignored.
- Reset mid-frame:
  - Return to IDLE and abandon the frame.
  - Clear the shift register, `inflight`, the FIFO and all counters.
  - `overflow` returning from abandoned points is discarded.

## Timing
- Reset values: `busy`, `done`, `c_valid`, `pix_valid`, `pix_data` = 0; `c_real`, `c_imag`, `pix_x`, `pix_y` = 0.
- Start latency:
  - `start` sampled at edge N → `busy` = 1 after N.
  - First `c_valid` = 1 after edge N+1.
- `c_valid`, `c_real`, `c_imag` are registered.
- Result timing:
  - A point issued with `c_valid` after edge K has its `overflow` sampled at edge K+LATENCY.
  - That entry is visible on `pix_valid` after edge K+LATENCY+1.
- Unstalled frame, with `pix_ready` held high: H_RES·V_RES issue cycles, then LATENCY+1 cycles to the last pixel, then `done` one cycle later.
- `busy` falls in the same cycle `done` pulses.

## Configuration
- `MANDEL_SCAN_PERFCNT_EN`:
  - Defined: adds output `stall_cycles` [31:0]. It counts RUN cycles in which issue was blocked by the credit rule, clears on accepted `start` and on reset, and holds after `done`.
  - Undefined: the port and counter are absent; behaviour is otherwise identical.

## Test plan
All scenarios use H_RES=4, V_RES=2, FIFO_DEPTH=4 unless stated, with a behavioural pipeline model of latency 14.
- Raster sweep: `x0`=0xF8000000, `y0`=0x00400000, `step`=0x00400000, `pix_ready`=1 → `c_real` = F8000000, F8400000, F8800000, F8C00000, repeated for row 1. `c_imag` = 00400000 for row 0 and 00000000 for row 1. 8 pixels arrive in raster order, and `done` pulses exactly once.
- Backpressure: `pix_ready`=0 → `c_valid` stops after 4 issues. Release `pix_ready` → all 8 pixels delivered, none lost or duplicated, order preserved.
- Data mapping: model returns `overflow` = 1 for odd columns → `pix_data` per row = 1,0,1,0.
- `start` pulsed during RUN and DRAIN → ignored; exactly one `done`; latched `x0` unchanged.
- `reset` asserted mid-RUN for one cycle:
  - Next cycle, all outputs are at reset values.
  - Stale `overflow` values are not delivered.
  - A new `start` produces a clean 8-pixel frame.
- Wrap: `x0`=0x7FC00000, `step`=0x00400000 → second `c_real` = 0x80000000, with no saturation.
